// File: rtl/vr_rr_arbiter.sv
// vr_rr_arbiter: NUM_REQ:1 round-robin valid/ready arbiter with a registered output stage.
// Defining VR_ARB_LOCK_EN holds the grant on one requester until it sends a word with in_last set.
module vr_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          in_valid,
   output logic [NUM_REQ-1:0]          in_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   in_data,
`ifdef VR_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]          in_last,
   output logic                        out_last,
`endif
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [$clog2(NUM_REQ)-1:0]  out_src
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0]   rr_ptr_r;
   logic [IDX_W-1:0]   ptr_nxt_s;
   logic [NUM_REQ-1:0] req_rot_s;
   logic [IDX_W:0]     cand_s;
   logic [IDX_W-1:0]   rr_grant_s;
   logic               rr_vld_s;
   logic [IDX_W-1:0]   grant_s;
   logic               grant_vld_s;
   logic               load_s;
   logic               in_xfer_s;
   logic [NUM_REQ-1:0] in_ready_s;
   logic [DATA_W-1:0]  sel_data_s;
   logic               out_valid_r;
   logic [DATA_W-1:0]  out_data_r;
   logic [IDX_W-1:0]   out_src_r;
`ifdef VR_ARB_LOCK_EN
   logic               locked_r;
   logic [IDX_W-1:0]   lock_src_r;
   logic               out_last_r;
`endif

   // Rotate the requests so bit 0 is rr_ptr; the lowest set bit wins, mapped back to an absolute index.
   always_comb begin
      req_rot_s  = NUM_REQ'({in_valid, in_valid} >> rr_ptr_r);
      rr_grant_s = '0;
      rr_vld_s   = 1'b0;
      cand_s     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand_s     = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
         cand_s     = (cand_s >= NUM_REQ_W) ? (cand_s - NUM_REQ_W) : cand_s;
         rr_grant_s = req_rot_s[k] ? cand_s[IDX_W-1:0] : rr_grant_s;
         rr_vld_s   = rr_vld_s | req_rot_s[k];
      end
   end

   // Final grant, handshake and payload select.
   always_comb begin
      grant_s     = rr_grant_s;
      grant_vld_s = rr_vld_s;
`ifdef VR_ARB_LOCK_EN
      if (locked_r) begin
         grant_s     = lock_src_r;
         grant_vld_s = in_valid[lock_src_r];
      end else begin
         grant_s     = rr_grant_s;
         grant_vld_s = rr_vld_s;
      end
`endif
      load_s     = !out_valid_r || out_ready;
      in_xfer_s  = !rst && grant_vld_s && load_s;
      in_ready_s = '0;
      if (in_xfer_s) begin
         in_ready_s[grant_s] = 1'b1;
      end else begin
         in_ready_s = '0;
      end
      ptr_nxt_s  = (grant_s == LAST_IDX) ? '0 : (grant_s + IDX_W'(1));
      sel_data_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel_data_s = (grant_s == IDX_W'(k)) ? in_data[k*DATA_W +: DATA_W] : sel_data_s;
      end
   end

   // Output register, round-robin pointer and packet lock state.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_src_r   <= '0;
         rr_ptr_r    <= '0;
`ifdef VR_ARB_LOCK_EN
         locked_r    <= 1'b0;
         lock_src_r  <= '0;
         out_last_r  <= 1'b0;
`endif
      end else begin
         if (in_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_src_r   <= grant_s;
         end else if (out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
`ifdef VR_ARB_LOCK_EN
         // The pointer only moves once a packet is complete.
         if (in_xfer_s) begin
            out_last_r <= in_last[grant_s];
            locked_r   <= !in_last[grant_s];
            lock_src_r <= grant_s;
            if (in_last[grant_s]) begin
               rr_ptr_r <= ptr_nxt_s;
            end else begin
               rr_ptr_r <= rr_ptr_r;
            end
         end else begin
            locked_r <= locked_r;
         end
`else
         if (in_xfer_s) begin
            rr_ptr_r <= ptr_nxt_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
`endif
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_src   = out_src_r;
`ifdef VR_ARB_LOCK_EN
   assign out_last  = out_last_r;
`endif

endmodule

// File: doc/vr_rr_arbiter.md
VR_RR_ARBITER -- requirements
Module: vr_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter DATA_W, default 32: payload width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, NUM_REQ: per-requester valid.
REQ-006 SHALL have port in_ready, output, NUM_REQ: per-requester ready.
REQ-007 SHALL have port in_data, input, NUM_REQ*DATA_W: payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port out_valid, output, 1: registered output valid.
REQ-009 SHALL have port out_ready, input, 1: downstream ready.
REQ-010 SHALL have port out_data, output, DATA_W: registered payload.
REQ-011 SHALL have port out_src, output, clog2(NUM_REQ): index of the requester that produced out_data.

Function
REQ-012 SHALL define a transfer on any port as valid && ready sampled high at a rising clk edge.
REQ-013 SHALL define load = !out_valid || out_ready; the output register accepts a new word only when load is high.
REQ-014 SHALL grant combinationally to the first requester i with in_valid[i] set, searching upward from rr_ptr and wrapping from NUM_REQ-1 to 0.
REQ-015 SHALL drive in_ready one-hot (or all zero): in_ready[g] = load for granted g; all others 0; all 0 when no in_valid is set.
REQ-016 SHALL, on an input transfer from g, register in_data[g] into out_data and g into out_src, and set out_valid on the next cycle (latency 1).
REQ-017 SHALL advance rr_ptr to (g+1) mod NUM_REQ on each input transfer; rr_ptr holds otherwise.
REQ-018 SHALL clear out_valid after an output transfer when no input transfer occurs in the same cycle.
REQ-019 SHALL, on simultaneous output transfer and input transfer, replace the output word with no bubble (1 word/cycle sustained).
REQ-020 SHALL hold out_data and out_src stable while out_valid && !out_ready.
REQ-021 SHALL never drop or duplicate a word; in_ready is never asserted to a requester whose in_valid is low.
REQ-022 SHALL guarantee that a continuously valid requester is served within NUM_REQ input transfers.

Reset
REQ-023 SHALL, while rst is high at a clk edge, set out_valid=0, out_data=0, out_src=0, rr_ptr=0, lock state cleared.
REQ-024 SHALL drive in_ready all zero while rst is high.
REQ-025 SHALL discard any word held in the output register when reset is asserted mid-stall; no transfer completes in a reset cycle.

Configuration
REQ-026 SHALL support macro VR_ARB_LOCK_EN; when undefined, the block is per-word round-robin exactly as in REQ-014..REQ-022.
REQ-027 SHALL, with VR_ARB_LOCK_EN defined, add input in_last (NUM_REQ) and output out_last (1, registered alongside out_data).
REQ-028 SHALL, with VR_ARB_LOCK_EN defined, lock the grant to g after an input transfer with in_last[g]=0, keep it locked until a transfer with in_last[g]=1, and advance rr_ptr only on that last transfer.
REQ-029 SHALL, while locked, keep in_ready=0 for all other requesters even when g has in_valid low.

Verification
REQ-030 SHALL cover: reset, then in_valid=4'b0001, in_data[0]=32'hAAAA, out_ready=0 -> out_valid=1 the next cycle, out_data=AAAA and out_src=0 held, in_ready[0]=0 until out_ready=1.
REQ-031 SHALL cover: all four requesters valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,... with one word per cycle.
REQ-032 SHALL cover: only requesters 1 and 3 valid, rr_ptr=2 -> requester 3 granted first, then 1.
REQ-033 SHALL cover: out_ready toggling 1,0,1 with requester 2 streaming 32'hBBBB0000+n -> in-order n sequence, no loss or duplication.
REQ-034 SHALL cover: rst asserted while out_valid=1 and out_ready=0 -> out_valid=0 on the next cycle, rr_ptr=0.
REQ-035 SHALL cover, with VR_ARB_LOCK_EN: requester 0 sends 3 words (last on the 3rd) while requester 1 is valid -> requester 1 granted only after the 3rd word, out_last=1 on it.
